// File: rtl/msrv32_alu_issue.sv
// msrv32_alu_issue: RV32I ALU-class decode/issue stage.
// Decodes one instruction into ALU operands, an ALU opcode and a destination
// register. It presents the result through a two-entry skid buffer so that
// in_ready_out comes straight from a flop and never combinationally from
// out_ready_in.
module msrv32_alu_issue #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [31:0]      instr_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] rs1_val_in,
    input  logic [WIDTH-1:0] rs2_val_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    output logic [WIDTH-1:0] op_1_out,
    output logic [WIDTH-1:0] op_2_out,
    output logic [3:0]       opcode_out,
    output logic [4:0]       rd_out,
    output logic             illegal_out,
    output logic             out_valid_out,
    input  logic             out_ready_in
);

    // Major opcodes accepted as ALU-class work
    localparam logic [6:0] MAJ_OP     = 7'b0110011;
    localparam logic [6:0] MAJ_OP_IMM = 7'b0010011;
    localparam logic [6:0] MAJ_LUI    = 7'b0110111;
    localparam logic [6:0] MAJ_AUIPC  = 7'b0010111;

    // ALU operation codes used directly by this stage
    localparam logic [3:0] ALU_ADD = 4'b0000;

    // funct3 values with special treatment
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SR      = 3'b101;

    // funct7 values that are legal for shifts and ADD/SUB
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // One decoded instruction as it travels through the buffer
    typedef struct packed {
        logic             illegal;
        logic [3:0]       opcode;
        logic [4:0]       rd;
        logic [WIDTH-1:0] op2;
        logic [WIDTH-1:0] op1;
    } payload_t;

    // Instruction fields
    logic [6:0]       major;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [WIDTH-1:0] i_imm;
    logic [WIDTH-1:0] u_imm;

    // Decoded payload for the instruction currently on the inputs
    payload_t dec;

    // Buffer state
    payload_t out_reg;
    payload_t skid_reg;
    logic     out_valid_reg;
    logic     skid_full_reg;
    logic     in_ready_reg;

    // Next-state controls
    logic out_valid_next;
    logic skid_full_next;
    logic load_out_dec;
    logic load_out_skid;
    logic load_skid;

    // Handshakes
    logic in_fire;
    logic out_fire;

    assign major  = instr_in[6:0];
    assign funct3 = instr_in[14:12];
    assign funct7 = instr_in[31:25];

    // I-type immediate sign-extended; U-type immediate placed in the upper bits
    assign i_imm = WIDTH'($signed(instr_in[31:20]));
    assign u_imm = WIDTH'($signed({instr_in[31:12], 12'b0}));

    assign in_fire  = in_valid_in & in_ready_reg;
    assign out_fire = out_valid_reg & out_ready_in;

    // Decode the input instruction into operands, ALU opcode and legality
    always_comb begin
        dec         = '0;
        dec.rd      = instr_in[11:7];
        case (major)
            MAJ_OP: begin
                dec.op1    = rs1_val_in;
                dec.op2    = rs2_val_in;
                dec.opcode = {instr_in[30], funct3};
                // Only bit 30 of funct7 may be set, and only for SUB and SRA
                if ((funct7 & ~F7_ALT) != F7_ZERO) begin
                    dec.illegal = 1'b1;
                end
                if (instr_in[30] && (funct3 != F3_ADD_SUB) && (funct3 != F3_SR)) begin
                    dec.illegal = 1'b1;
                end
            end
            MAJ_OP_IMM: begin
                dec.op1 = rs1_val_in;
                dec.op2 = i_imm;
                // Bit 30 selects SRAI over SRLI; for the others it is immediate data
                if (funct3 == F3_SR) begin
                    dec.opcode = {instr_in[30], funct3};
                end else begin
                    dec.opcode = {1'b0, funct3};
                end
                if ((funct3 == F3_SLL) && (funct7 != F7_ZERO)) begin
                    dec.illegal = 1'b1;
                end
                if ((funct3 == F3_SR) && (funct7 != F7_ZERO) && (funct7 != F7_ALT)) begin
                    dec.illegal = 1'b1;
                end
            end
            MAJ_LUI: begin
                dec.op1    = '0;
                dec.op2    = u_imm;
                dec.opcode = ALU_ADD;
            end
            MAJ_AUIPC: begin
                dec.op1    = pc_in;
                dec.op2    = u_imm;
                dec.opcode = ALU_ADD;
            end
            default: begin
                // Non-ALU instruction: operands and opcode stay zero
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Decide where the incoming and skidded instructions go this cycle
    always_comb begin
        out_valid_next = out_valid_reg;
        skid_full_next = skid_full_reg;
        load_out_dec   = 1'b0;
        load_out_skid  = 1'b0;
        load_skid      = 1'b0;
        if (skid_full_reg) begin
            // Input is stalled; the skid entry advances once the output drains
            if (out_fire) begin
                load_out_skid  = 1'b1;
                skid_full_next = 1'b0;
            end
        end else if (!out_valid_reg || out_fire) begin
            // Output stage is free this cycle, so new work goes straight there
            if (in_fire) begin
                load_out_dec   = 1'b1;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (in_fire) begin
            // Output is stalled; park the accepted instruction in the skid slot
            load_skid      = 1'b1;
            skid_full_next = 1'b1;
        end
    end

    // Control flops; in_ready is registered as the inverse of the next skid state
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_valid_reg <= 1'b0;
            skid_full_reg <= 1'b0;
            in_ready_reg  <= 1'b0;
        end else begin
            out_valid_reg <= out_valid_next;
            skid_full_reg <= skid_full_next;
            in_ready_reg  <= ~skid_full_next;
        end
    end

    // Output register: loads fresh decode or the skid entry, otherwise holds
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_reg <= '0;
        end else if (load_out_skid) begin
            out_reg <= skid_reg;
        end else if (load_out_dec) begin
            out_reg <= dec;
        end
    end

    // Skid register: captures an instruction accepted while the output stalls
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            skid_reg <= '0;
        end else if (load_skid) begin
            skid_reg <= dec;
        end
    end

    assign in_ready_out  = in_ready_reg;
    assign out_valid_out = out_valid_reg;
    assign op_1_out      = out_reg.op1;
    assign op_2_out      = out_reg.op2;
    assign opcode_out    = out_reg.opcode;
    assign rd_out        = out_reg.rd;
    assign illegal_out   = out_reg.illegal;

endmodule

// File: tb/tb_msrv32_alu_issue.sv
// Testbench for msrv32_alu_issue: directed checks followed by a randomized
// run scored against a queue-based reference model.
module tb_msrv32_alu_issue;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [31:0]  instr;
    logic [W-1:0] pc;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_1;
    logic [W-1:0] op_2;
    logic [3:0]   opcode;
    logic [4:0]   rd;
    logic         illegal;
    logic         out_valid;
    logic         out_ready;

    msrv32_alu_issue #(.WIDTH(W)) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .instr_in     (instr),
        .pc_in        (pc),
        .rs1_val_in   (rs1),
        .rs2_val_in   (rs2),
        .in_valid_in  (in_valid),
        .in_ready_out (in_ready),
        .op_1_out     (op_1),
        .op_2_out     (op_2),
        .opcode_out   (opcode),
        .rd_out       (rd),
        .illegal_out  (illegal),
        .out_valid_out(out_valid),
        .out_ready_in (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  opc;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_fields(input string tag, input exp_t e);
        chk({tag, "_op1"},    op_1,          e.op1);
        chk({tag, "_op2"},    op_2,          e.op2);
        chk({tag, "_opcode"}, 32'(opcode),   32'(e.opc));
        chk({tag, "_rd"},     32'(rd),       32'(e.rd));
        chk({tag, "_illegal"},32'(illegal),  32'(e.ill));
    endtask

    function automatic exp_t mk(input logic [31:0] o1, input logic [31:0] o2,
                                input logic [3:0] oc, input logic [4:0] r, input logic il);
        exp_t e;
        e.op1 = o1; e.op2 = o2; e.opc = oc; e.rd = r; e.ill = il;
        return e;
    endfunction

    // Reference decode written from the instruction-set rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   f3;
        int   f7;
        int   imm;
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        e = '0;
        e.rd = ins[11:7];
        if (ins[6:0] == 7'h33) begin
            e.op1 = a;
            e.op2 = b;
            e.opc = 4'((ins[30] ? 8 : 0) + f3);
            e.ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
        end else if (ins[6:0] == 7'h13) begin
            imm = int'(ins[31:20]);
            if (imm >= 2048) imm = imm - 4096;
            e.op1 = a;
            e.op2 = 32'(imm);
            e.opc = 4'(f3 + ((f3 == 5 && ins[30]) ? 8 : 0));
            e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
        end else if (ins[6:0] == 7'h37) begin
            e.op2 = ins & 32'hFFFF_F000;
        end else if (ins[6:0] == 7'h17) begin
            e.op1 = p;
            e.op2 = ins & 32'hFFFF_F000;
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 5))
            0: begin
                ins[6:0] = 7'h33;
                if ($urandom_range(0, 4) != 0)
                    ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            1: begin
                ins[6:0] = 7'h13;
                if ($urandom_range(0, 2) != 0)
                    ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            2: ins[6:0] = 7'h37;
            3: ins[6:0] = 7'h17;
            4: ins[6:0] = 7'h13;
            default: ;
        endcase
        return ins;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one instruction with the output free, check it a cycle later, drain it
    task automatic issue_one(input string tag, input logic [31:0] ins, input logic [31:0] p,
                             input logic [31:0] a, input logic [31:0] b, input exp_t e);
        out_ready = 1'b1;
        instr = ins; pc = p; rs1 = a; rs2 = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk_fields(tag, e);
        $display("txn %s: instr=0x%08h op1=0x%08h op2=0x%08h opcode=%h rd=%0d illegal=%0b",
                 tag, ins, op_1, op_2, opcode, rd, illegal);
        tick();
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h40208233;
    localparam logic [31:0] I_XOR   = 32'h0020C333;
    localparam logic [31:0] I_SRAI  = 32'h40415093;
    localparam logic [31:0] I_SRLI  = 32'h00415093;
    localparam logic [31:0] I_AUIPC = 32'h12345297;
    localparam logic [31:0] I_LUI   = 32'h123452B7;
    localparam logic [31:0] I_LOAD  = 32'h00002083;

    exp_t q[$];

    initial begin
        exp_t e;
        logic in_fire;
        logic out_fire;
        int   bound;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0; rs1 = '0; rs2 = '0;

        // Reset state
        #3;
        chk("reset_valid",    32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready),  32'd0);
        chk("reset_op1",      op_1,           32'd0);
        chk("reset_op2",      op_2,           32'd0);
        chk("reset_opcode",   32'(opcode),    32'd0);
        chk("reset_rd",       32'(rd),        32'd0);
        chk("reset_illegal",  32'(illegal),   32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("release_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("release_ready_high", 32'(in_ready), 32'd1);

        // Single-instruction decode cases
        issue_one("add",   I_ADD,   32'h0,   32'd5,          32'd7, mk(32'd5, 32'd7, 4'h0, 5'd3, 1'b0));
        issue_one("srai",  I_SRAI,  32'h0,   32'h8000_0000,  32'd0, mk(32'h8000_0000, 32'h404, 4'hD, 5'd1, 1'b0));
        issue_one("srli",  I_SRLI,  32'h0,   32'h8000_0000,  32'd0, mk(32'h8000_0000, 32'h004, 4'h5, 5'd1, 1'b0));
        issue_one("auipc", I_AUIPC, 32'h100, 32'd1,          32'd2, mk(32'h100, 32'h1234_5000, 4'h0, 5'd5, 1'b0));
        issue_one("lui",   I_LUI,   32'h100, 32'd1,          32'd2, mk(32'h0, 32'h1234_5000, 4'h0, 5'd5, 1'b0));
        issue_one("load",  I_LOAD,  32'h100, 32'd1,          32'd2, mk(32'h0, 32'h0, 4'h0, 5'd1, 1'b1));

        // Back-to-back with the output stalled: two accepted, third held off
        out_ready = 1'b0;
        rs1 = 32'd9; rs2 = 32'd4; pc = 32'h0;
        in_valid = 1'b1; instr = I_ADD;
        tick();
        chk("bp1_ready", 32'(in_ready),  32'd1);
        chk("bp1_valid", 32'(out_valid), 32'd1);
        chk("bp1_rd",    32'(rd),        32'd3);
        instr = I_SUB;
        tick();
        chk("bp2_ready", 32'(in_ready), 32'd0);
        chk("bp2_rd",    32'(rd),       32'd3);
        chk("bp2_op1",   op_1,          32'd9);
        instr = I_XOR;
        tick();
        chk("bp3_ready",  32'(in_ready), 32'd0);
        chk("bp3_rd",     32'(rd),       32'd3);
        chk("bp3_opcode", 32'(opcode),   32'd0);
        chk("bp3_op2",    op_2,          32'd4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp4_ready",  32'(in_ready),  32'd1);
        chk("bp4_valid",  32'(out_valid), 32'd1);
        chk("bp4_rd",     32'(rd),        32'd4);
        chk("bp4_opcode", 32'(opcode),    32'd8);
        tick();
        chk("bp5_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset with both entries occupied
        out_ready = 1'b0;
        in_valid = 1'b1; instr = I_ADD;
        tick();
        instr = I_SUB;
        tick();
        in_valid = 1'b0;
        chk("full_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(in_ready),  32'd0);
        chk("arst_op1",   op_1,           32'd0);
        chk("arst_rd",    32'(rd),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_rel_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("arst_rel_ready_high", 32'(in_ready),  32'd1);
        chk("arst_rel_empty",      32'(out_valid), 32'd0);

        // Randomized traffic scored against the queue model
        for (int cyc = 0; cyc < 600; cyc++) begin
            chk("rnd_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("rnd_ready", 32'(in_ready),  32'(q.size() < 2));
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = gen_instr();
            pc        = $urandom;
            rs1       = $urandom;
            rs2       = $urandom;
            out_ready = ((cyc / 40) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                              : ($urandom_range(0, 2) != 0);
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                chk_fields("rnd", q[0]);
                $display("txn %0d: out op1=0x%08h op2=0x%08h opcode=%h rd=%0d illegal=%0b",
                         cyc, op_1, op_2, opcode, rd, illegal);
            end
            e = model(instr, pc, rs1, rs2);
            tick();
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(e);
        end

        // Drain remaining entries
        in_valid = 1'b0;
        out_ready = 1'b1;
        bound = 0;
        while (q.size() > 0 && bound < 10) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk_fields("drain", q[0]);
            void'(q.pop_front());
            tick();
            bound++;
        end
        chk("drain_queue_empty", 32'(q.size()),  32'd0);
        chk("drain_out_empty",   32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/msrv32_alu_issue.md
MSRV32_ALU_ISSUE -- requirements
Module: msrv32_alu_issue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath width of the operand, PC and result buses.
REQ-002 The block SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port instr_in, input, 32 bits: the RV32I instruction word.
REQ-005 The block SHALL have port pc_in, input, WIDTH bits: the PC of the instruction.
REQ-006 The block SHALL have ports rs1_val_in and rs2_val_in, input, WIDTH bits each: the register-file read data.
REQ-007 The block SHALL have port in_valid_in, input, 1 bit; and port in_ready_out, output, 1 bit.
REQ-008 The block SHALL have ports op_1_out and op_2_out, output, WIDTH bits each: the ALU operands.
REQ-009 The block SHALL have port opcode_out, output, 4 bits: the ALU operation code.
REQ-010 The block SHALL have port rd_out, output, 5 bits: the destination register index.
REQ-011 The block SHALL have port illegal_out, output, 1 bit: the instruction is not an ALU-class instruction.
REQ-012 The block SHALL have port out_valid_out, output, 1 bit; and port out_ready_in, input, 1 bit.

Function
REQ-013 The block SHALL transfer input on a clock edge where in_valid_in=1 and in_ready_out=1, and output on an edge where out_valid_out=1 and out_ready_in=1.
REQ-014 The block SHALL decode major opcode instr[6:0]: OP=0110011, OP-IMM=0010011, LUI=0110111, AUIPC=0010111; any other major opcode SHALL set illegal_out=1, opcode_out=0000, op_1_out=0 and op_2_out=0.
REQ-015 The block SHALL encode opcode_out as ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-016 For OP, the block SHALL set opcode_out={instr[30],instr[14:12]}, op_1_out=rs1_val_in and op_2_out=rs2_val_in.
REQ-017 For OP with instr[30]=1 and funct3 not in {000,101}, or with funct7 bits other than bit 30 nonzero, the block SHALL set illegal_out=1.
REQ-018 For OP-IMM, the block SHALL set op_1_out=rs1_val_in and op_2_out=sign-extended instr[31:20].
REQ-019 For OP-IMM, opcode_out SHALL be {instr[30],funct3} when funct3=101, and {0,funct3} for every other funct3.
REQ-020 For OP-IMM with funct3=001 and instr[31:25]!=0, or funct3=101 and instr[31:25] not in {0000000,0100000}, the block SHALL set illegal_out=1.
REQ-021 For LUI, the block SHALL set op_1_out=0, op_2_out={instr[31:12],12'b0} and opcode_out=ADD.
REQ-022 For AUIPC, the block SHALL set op_1_out=pc_in, op_2_out={instr[31:12],12'b0} and opcode_out=ADD.
REQ-023 The block SHALL set rd_out=instr[11:7] for all instructions.
REQ-024 The output SHALL be registered: latency 1 cycle from input transfer to out_valid_out=1 when the output stage is empty.
REQ-025 Buffering SHALL be a 2-entry skid: output register plus one skid register.
REQ-026 in_ready_out SHALL be driven directly from a flop and equal NOT skid_full; it SHALL have no combinational path from out_ready_in.
REQ-027 With the output register full and out_ready_in=0, an input transfer SHALL be captured in the skid register and in_ready_out SHALL drop on the next cycle.
REQ-028 When the output transfers while the skid is full, the skid content SHALL move to the output register and in_ready_out SHALL rise on the next cycle.
REQ-029 On a simultaneous input and output transfer with the skid empty, the output register SHALL load the new decoded instruction and out_valid_out SHALL stay 1.
REQ-030 Output fields SHALL be held stable while out_valid_out=1 and out_ready_in=0.
REQ-031 Ordering SHALL be strict FIFO; no instruction SHALL be dropped or duplicated.

Reset
REQ-032 Assertion of rst_n_in=0 SHALL immediately clear out_valid_out to 0, clear skid_full to 0, force in_ready_out to 0, and zero op_1_out, op_2_out, opcode_out, rd_out and illegal_out.
REQ-033 in_ready_out SHALL rise on the first clock edge after rst_n_in deasserts.
REQ-034 Reset mid-operation SHALL discard all buffered instructions.

Verification
REQ-035 The bench SHALL apply ADD x3,x1,x2 (0x002081B3) with rs1=5 and rs2=7, and check op_1=5, op_2=7, opcode=0000, rd=3, illegal=0, valid 1 cycle later.
REQ-036 The bench SHALL apply SRAI x1,x2,4 (0x40415093) with rs1=0x80000000, and check opcode=1101, op_2=0x404; and check SRLI (0x00415093) gives opcode=0101.
REQ-037 The bench SHALL apply AUIPC x5,0x12345 with pc=0x100, and check op_1=0x100, op_2=0x12345000, opcode=0000; and check LUI gives op_1=0.
REQ-038 The bench SHALL hold out_ready_in=0 and send 3 back-to-back instructions, and check that 2 are accepted, in_ready drops, outputs are stable, and release drains them in order.
REQ-039 The bench SHALL apply a load instruction (0x00002083), and check illegal=1, opcode=0000, operands 0.
REQ-040 The bench SHALL assert rst_n_in asynchronously with both entries full, and check valid=0 and in_ready=0 immediately, and in_ready=1 one edge after release.
